// File: rtl/axil_crossbar_grant_rd.sv
// Read-channel grant FSM for an AXI-Lite crossbar: decodes one read address,
// holds a one-hot slave grant for the transaction, and answers unmapped reads with DECERR.
module axil_crossbar_grant_rd #(
    parameter int NUMBER_SLAVE   = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter logic [NUMBER_SLAVE*AXI_ADDR_WIDTH-1:0] SLAVE_BASE_ADDR = '0,
    parameter logic [NUMBER_SLAVE*AXI_ADDR_WIDTH-1:0] SLAVE_ADDR_MASK = '0
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [AXI_ADDR_WIDTH-1:0] m_axil_araddr,
    input  logic                      m_axil_arvalid,
    input  logic                      m_axil_arready,
    input  logic                      m_axil_rvalid,
    input  logic                      m_axil_rready,
    output logic [NUMBER_SLAVE-1:0]   grant_rd_trans,
    output logic [NUMBER_SLAVE-1:0]   s_axil_arvalid,
    output logic [NUMBER_SLAVE-1:0]   s_axil_rready,
    output logic                      err_arready,
    output logic                      err_rvalid,
    output logic [1:0]                err_rresp,
    output logic                      busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        ERR_ADDR,
        ERR_DATA
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [NUMBER_SLAVE-1:0] grant_reg;
    logic [NUMBER_SLAVE-1:0] grant_next;
    logic [NUMBER_SLAVE-1:0] hit;
    logic [NUMBER_SLAVE-1:0] hit_onehot;

    generate
        for (genvar gi = 0; gi < NUMBER_SLAVE; gi++) begin : g_decode
            assign hit[gi] = ((m_axil_araddr & SLAVE_ADDR_MASK[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH])
                              == SLAVE_BASE_ADDR[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]);
        end
    endgenerate

    // Isolate the lowest set bit so overlapping windows resolve to the lowest slave index.
    assign hit_onehot = hit & (~hit + NUMBER_SLAVE'(1));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg <= IDLE;
            grant_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        s_axil_arvalid = '0;
        s_axil_rready  = '0;
        err_arready    = 1'b0;
        err_rvalid     = 1'b0;
        err_rresp      = 2'b00;
        case (state_reg)
            IDLE: begin
                grant_next = '0;
                if (m_axil_arvalid) begin
                    if (|hit) begin
                        state_next = ADDR;
                        grant_next = hit_onehot;
                    end else begin
                        state_next = ERR_ADDR;
                    end
                end
            end
            ADDR: begin
                s_axil_arvalid = grant_reg & {NUMBER_SLAVE{m_axil_arvalid}};
                // A concurrent rvalid here is ignored; the beat is taken in DATA.
                if (m_axil_arvalid && m_axil_arready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                s_axil_rready = grant_reg & {NUMBER_SLAVE{m_axil_rready}};
                if (m_axil_rvalid && m_axil_rready) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            ERR_ADDR: begin
                err_arready = 1'b1;
                state_next  = ERR_DATA;
            end
            ERR_DATA: begin
                err_rvalid = 1'b1;
                err_rresp  = 2'b11;
                if (m_axil_rready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    assign grant_rd_trans = grant_reg;
    assign busy           = (state_reg != IDLE);

endmodule
